// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD encoder/decoder family: FSM encoding,
// default sizing and the largest legal BCD digit.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          DIGITS  = 4;
    localparam int          BIN_W   = 14;
    localparam logic [3:0]  BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_mac10.sv
// One Horner step of BCD-to-binary conversion: acc*10 + digit, plus a flag
// for a digit outside 0..9. Purely combinational.
module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int BIN_W = bcd_pkg::BIN_W
) (
    input  logic [BIN_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [BIN_W-1:0] acc_next,
    output logic             illegal
);

    // Shift-and-add keeps the multiply out of the datapath; result wraps at BIN_W.
    always_comb begin
        acc_next = (acc << 3) + (acc << 1) + BIN_W'(digit);
        illegal  = (digit > BCD_MAX);
    end

endmodule

// File: rtl/bcd2bin_4digits.sv
// Multi-cycle packed-BCD to binary converter: one digit per cycle, MSB first,
// registered result with a validity flag and a one-cycle done pulse.
module bcd2bin_4digits #(
    parameter int DIGITS = bcd_pkg::DIGITS,
    parameter int BIN_W  = bcd_pkg::BIN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                EN,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd,
    output logic [BIN_W-1:0]    bin,
    output logic                valid,
    output logic                busy,
    output logic                done
);

    import bcd_pkg::*;

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                state, state_next;
    logic [4*DIGITS-1:0]   sreg;
    logic [BIN_W-1:0]      acc;
    logic [BIN_W-1:0]      acc_next;
    logic [CNT_W-1:0]      cnt;
    logic                  err;
    logic                  illegal;
    logic                  last;
    logic                  err_final;
    logic [3:0]            digit;

    assign digit     = sreg[4*DIGITS-1 -: 4];
    assign last      = (cnt == CNT_W'(DIGITS - 1));
    assign err_final = err | illegal;

    bcd_mac10 #(
        .BIN_W (BIN_W)
    ) u_mac10 (
        .acc      (acc),
        .digit    (digit),
        .acc_next (acc_next),
        .illegal  (illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start && EN) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (!EN) begin
                    state_next = IDLE;
                end else if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result registers load only on the CONV->DONE edge, using the final
    // digit's contribution directly so DONE already shows the answer.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg  <= '0;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            bin   <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && EN) begin
                        sreg <= bcd;
                        acc  <= '0;
                        cnt  <= '0;
                        err  <= 1'b0;
                    end
                end
                CONV: begin
                    if (EN) begin
                        acc  <= acc_next;
                        sreg <= {sreg[4*DIGITS-5:0], 4'h0};
                        cnt  <= cnt + 1'b1;
                        err  <= err_final;
                        if (last) begin
                            bin   <= err_final ? '0 : acc_next;
                            valid <= ~err_final;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_4digits.sv
// Directed bench for bcd2bin_4digits: latency, legal/illegal inputs,
// back-to-back requests, reset and enable aborts.
module tb_bcd2bin_4digits;

    logic        clk = 1'b0;
    logic        rst;
    logic        EN;
    logic        start;
    logic [15:0] bcd;
    logic [13:0] bin;
    logic        valid;
    logic        busy;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    logic [13:0] last_bin;
    logic        last_valid;

    always #5 clk = ~clk;

    bcd2bin_4digits #(
        .DIGITS (4),
        .BIN_W  (14)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .EN    (EN),
        .start (start),
        .bcd   (bcd),
        .bin   (bin),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full conversion; bcd is scrambled right after acceptance to prove it is latched.
    task automatic run(input string tag, input logic [15:0] v,
                       input logic [13:0] eb, input logic ev);
        bcd   = v;
        start = 1'b1;
        EN    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_done"}, 32'(done), (c == 5) ? 32'd1 : 32'd0);
            if (c < 5) begin
                chk({tag, "_binhold"}, 32'(bin), 32'(last_bin));
                chk({tag, "_validhold"}, 32'(valid), 32'(last_valid));
            end else begin
                chk({tag, "_bin"}, 32'(bin), 32'(eb));
                chk({tag, "_valid"}, 32'(valid), 32'(ev));
            end
            if (c == 1) bcd = ~v;
        end
        tick();
        chk({tag, "_idlebusy"}, 32'(busy), 32'd0);
        chk({tag, "_idledone"}, 32'(done), 32'd0);
        chk({tag, "_keepbin"}, 32'(bin), 32'(eb));
        last_bin   = eb;
        last_valid = ev;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        EN    = 1'b0;
        start = 1'b0;
        bcd   = 16'h0000;
        tick();
        tick();
        chk("rst_bin", 32'(bin), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        last_bin   = 14'd0;
        last_valid = 1'b0;
        rst = 1'b0;

        run("c1234", 16'h1234, 14'h04D2, 1'b1);
        run("c9999", 16'h9999, 14'h270F, 1'b1);
        run("c0000", 16'h0000, 14'h0000, 1'b1);
        run("c12A4", 16'h12A4, 14'h0000, 1'b0);
        run("c0042", 16'h0042, 14'h002A, 1'b1);

        // start held high: accepts at cycle 0 and 6, done at cycles 5 and 11
        bcd   = 16'h0007;
        start = 1'b1;
        EN    = 1'b1;
        tick();
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) tick();
            chk("b2b_done", 32'(done), (c == 5 || c == 11) ? 32'd1 : 32'd0);
            chk("b2b_busy", 32'(busy), (c == 6) ? 32'd0 : 32'd1);
            if (c == 5 || c == 11) begin
                chk("b2b_bin", 32'(bin), 32'd7);
                chk("b2b_valid", 32'(valid), 32'd1);
            end
            if (c == 7) bcd = 16'h0005;
        end
        start = 1'b0;
        tick();
        chk("b2b_end_busy", 32'(busy), 32'd0);

        // reset in the third CONV cycle
        bcd   = 16'h1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("rmid_busy3", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("rmid_bin", 32'(bin), 32'd0);
        chk("rmid_valid", 32'(valid), 32'd0);
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_done", 32'(done), 32'd0);
        rst        = 1'b0;
        last_bin   = 14'd0;
        last_valid = 1'b0;
        run("postrst", 16'h0042, 14'h002A, 1'b1);

        // EN dropped mid-conversion: abort, no done, result kept
        bcd   = 16'h0099;
        start = 1'b1;
        EN    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        EN = 1'b0;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bin", 32'(bin), 32'h2A);
        chk("abort_valid", 32'(valid), 32'd1);
        EN = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("abort_nodone", 32'(done), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd2bin_4digits.md
BCD2BIN_4DIGITS -- requirements
Module: bcd2bin_4digits

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits converted.
REQ-002 SHALL have parameter BIN_W, default 14: result width, enough to hold 9999.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port EN, input, 1 bit: block enable.
REQ-006 SHALL have port start, input, 1 bit: conversion request, sampled at the clk edge.
REQ-007 SHALL have port bcd, input, 16 bits: four packed BCD digits, bcd[15:12] being the most significant.
REQ-008 SHALL have port bin, output, 14 bits: binary result, registered.
REQ-009 SHALL have port valid, output, 1 bit: high when the last result came from legal BCD, registered.
REQ-010 SHALL have port busy, output, 1 bit: high while a conversion is in flight.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 SHALL use an FSM with three states: IDLE, CONV and DONE.
REQ-013 SHALL accept a request only in IDLE with start=1 and EN=1; on that edge it latches bcd into a shift register, clears accumulator and digit counter, and enters CONV.
REQ-014 SHALL process exactly one digit per CONV cycle, MSB first: acc = acc*10 + digit, with acc*10 formed as (acc<<3)+(acc<<1), and no overflow beyond BIN_W bits.
REQ-015 SHALL flag a digit above 9 as illegal, OR it into a sticky error bit, and continue the conversion.
REQ-016 SHALL leave CONV for DONE after the 4th digit; DONE lasts exactly one cycle, then returns to IDLE.
REQ-017 SHALL, on the edge entering DONE, load bin with acc and set valid=1 when no error occurred; on error it loads bin=0 and valid=0.
REQ-018 SHALL set done=1 only in the DONE cycle, i.e. the 5th cycle after the accepting edge, giving a latency of 5 cycles.
REQ-019 SHALL keep busy=1 in CONV and DONE, and busy=0 in IDLE.
REQ-020 SHALL ignore start while busy=1, with no queuing; a new request is accepted at the earliest in the cycle after done.
REQ-021 SHALL hold bin and valid between completions; they change only on entry to DONE.
REQ-022 SHALL abort when EN=0 during CONV: return to IDLE on the next edge with no done pulse, bin and valid unchanged.
REQ-023 SHALL let the DONE cycle complete normally even if EN=0 during it.
REQ-024 SHALL ignore changes on bcd after the accepting edge.

Reset
REQ-025 SHALL, when rst=1 at any clk edge, force state IDLE, bin=0, valid=0, busy=0, done=0, and clear the accumulator, counter and error bit.
REQ-026 SHALL give rst priority over start and EN; a reset mid-conversion discards the conversion with no done pulse.
REQ-027 SHALL accept a request with start=1 in the first cycle after rst falls.

Structure
REQ-028 SHALL place the state encoding, DIGITS, BIN_W and the BCD digit maximum (9) in shared package bcd_pkg, reused by the encoder family.
REQ-029 SHALL use one combinational sub-module, bcd_mac10, computing acc*10+digit and the illegal-digit flag.

Verification
REQ-030 SHALL cover: bcd=16'h1234, start 1 cycle -> busy 4+1 cycles, done at cycle 5, bin=1234 (14'h04D2), valid=1.
REQ-031 SHALL cover: bcd=16'h9999 -> bin=9999 (14'h270F), valid=1; bcd=16'h0000 -> bin=0, valid=1.
REQ-032 SHALL cover: bcd=16'h12A4 -> done at cycle 5, bin=0, valid=0; a following 16'h0042 -> bin=42, valid=1.
REQ-033 SHALL cover: start held high continuously with bcd=16'h0007 -> done every 6 cycles, the second bcd change mid-conversion ignored.
REQ-034 SHALL cover: rst=1 in the 3rd CONV cycle -> next cycle all outputs 0, no done; EN=0 in CONV -> IDLE, no done, prior bin kept.
